// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store stage with split read/write bus, lane extract and WB hold
module lsu_mem_ctrl #(
  parameter int         XLEN    = 64,
  parameter int         AW      = 32,
  parameter int         RD_W    = 5,
  parameter logic [3:0] DEV_TOP = 4'hA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [AW-1:0]     in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wen,
  input  logic [XLEN-1:0]   in_res,
  output logic              ar_valid,
  input  logic              ar_ready,
  output logic [AW-1:0]     ar_addr,
  output logic              ar_dev,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [XLEN-1:0]   r_data,
  input  logic              r_err,
  output logic              aw_valid,
  input  logic              aw_ready,
  output logic [AW-1:0]     aw_addr,
  output logic              aw_dev,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [XLEN-1:0]   w_data,
  output logic [XLEN/8-1:0] w_strb,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wen,
  output logic [XLEN-1:0]   out_data,
  output logic              out_err,
  output logic              fwd_busy,
  output logic              fwd_wen,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [XLEN-1:0]   fwd_data
);

  localparam int SB   = XLEN / 8;
  localparam int OFFW = $clog2(SB);
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, HOLD} state_t;

  state_t            state, state_nx;
  logic              accept;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [AW-1:0]     addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [SB-1:0]     strb_q;
  logic [RD_W-1:0]   rd_q;
  logic              wen_q;
  logic [XLEN-1:0]   data_q;
  logic              err_q;
  logic              aw_done, w_done;

  // Decode of the incoming op: access width, alignment and byte-lane placement
  logic [3:0]        nbytes;
  logic              misalign;
  logic              is_mem;
  logic [OFFW-1:0]   off_in;
  logic [SB-1:0]     strb_in;
  logic [XLEN-1:0]   wdata_in;

  assign nbytes   = 4'd1 << in_size;
  assign misalign = (|(in_addr[3:0] & (nbytes - 4'd1))) || ((XLEN == 32) && (in_size == 2'd3));
  assign is_mem   = (in_op == OP_LOAD) || (in_op == OP_STORE);
  assign off_in   = in_addr[OFFW-1:0];
  assign strb_in  = (~({SB{1'b1}} << nbytes)) << off_in;
  assign wdata_in = in_wdata << {off_in, 3'b000};

  // Load lane extraction: shift the lane down, then sign/zero extend via a shift pair
  logic [6:0]             ext_sh;
  logic [XLEN-1:0]        lane, up, zext, load_val;
  logic signed [XLEN-1:0] sext;

  // Extension shift amount for the latched access size
  always_comb begin
    ext_sh = '0;
    case (size_q)
      2'd0:    ext_sh = 7'(XLEN - 8);
      2'd1:    ext_sh = 7'(XLEN - 16);
      2'd2:    ext_sh = 7'(XLEN - 32);
      default: ext_sh = '0;
    endcase
  end

  assign lane     = r_data >> {addr_q[OFFW-1:0], 3'b000};
  assign up       = lane << ext_sh;
  assign zext     = up >> ext_sh;
  assign sext     = $signed(up) >>> ext_sh;
  assign load_val = uns_q ? zext : $unsigned(sext);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake outputs; HOLD can retire and accept in the same cycle
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    ar_valid  = 1'b0;
    r_ready   = 1'b0;
    aw_valid  = 1'b0;
    w_valid   = 1'b0;
    b_ready   = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE:  in_ready = 1'b1;
      RADDR: begin
        ar_valid = 1'b1;
        if (ar_ready) state_nx = RDATA;
      end
      RDATA: begin
        r_ready = 1'b1;
        if (r_valid) state_nx = HOLD;
      end
      WREQ: begin
        aw_valid = !aw_done;
        w_valid  = !w_done;
        if ((aw_done || aw_ready) && (w_done || w_ready)) state_nx = WRESP;
      end
      WRESP: begin
        b_ready = 1'b1;
        if (b_valid) state_nx = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    accept = in_valid && in_ready;
    if (accept) begin
      if (is_mem && misalign)       state_nx = HOLD;
      else if (in_op == OP_LOAD)    state_nx = RADDR;
      else if (in_op == OP_STORE)   state_nx = WREQ;
      else                          state_nx = HOLD;
    end
  end

  // Op latch, write-channel progress and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (accept) begin
        size_q  <= in_size;
        uns_q   <= in_unsigned;
        addr_q  <= in_addr;
        wdata_q <= wdata_in;
        strb_q  <= strb_in;
        rd_q    <= in_rd;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        err_q   <= 1'b0;
        data_q  <= '0;
        if (is_mem && misalign) begin
          wen_q <= 1'b0;
          err_q <= 1'b1;
        end else if (in_op == OP_STORE) begin
          wen_q <= 1'b0;
        end else if (in_op == OP_LOAD) begin
          wen_q <= in_wen;
        end else begin
          wen_q  <= in_wen;
          data_q <= in_res;
        end
      end
      if (state == WREQ) begin
        if (aw_valid && aw_ready) aw_done <= 1'b1;
        if (w_valid && w_ready)   w_done  <= 1'b1;
      end
      if (state == RDATA && r_valid) begin
        data_q <= load_val;
        err_q  <= r_err;
        if (r_err) wen_q <= 1'b0;
      end
      if (state == WRESP && b_valid) err_q <= b_err;
    end
  end

  assign ar_addr  = {addr_q[AW-1:OFFW], {OFFW{1'b0}}};
  assign aw_addr  = {addr_q[AW-1:OFFW], {OFFW{1'b0}}};
  assign ar_dev   = (addr_q[AW-1:AW-4] == DEV_TOP);
  assign aw_dev   = (addr_q[AW-1:AW-4] == DEV_TOP);
  assign w_data   = wdata_q;
  assign w_strb   = strb_q;
  assign out_rd   = rd_q;
  assign out_wen  = wen_q;
  assign out_data = data_q;
  assign out_err  = err_q;
  assign fwd_busy = (state == RADDR) || (state == RDATA);
  assign fwd_wen  = (state != IDLE) && wen_q;
  assign fwd_rd   = rd_q;
  assign fwd_data = data_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed vector bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;
  localparam int XLEN = 64;
  localparam int AW   = 32;
  localparam int RD_W = 5;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, in_unsigned, in_wen;
  logic [1:0] in_op, in_size;
  logic [AW-1:0] in_addr;
  logic [XLEN-1:0] in_wdata, in_res;
  logic [RD_W-1:0] in_rd;
  logic ar_valid, ar_ready, ar_dev;
  logic [AW-1:0] ar_addr;
  logic r_valid, r_ready, r_err;
  logic [XLEN-1:0] r_data;
  logic aw_valid, aw_ready, aw_dev;
  logic [AW-1:0] aw_addr;
  logic w_valid, w_ready;
  logic [XLEN-1:0] w_data;
  logic [XLEN/8-1:0] w_strb;
  logic b_valid, b_ready, b_err;
  logic out_valid, out_ready, out_wen, out_err;
  logic [RD_W-1:0] out_rd;
  logic [XLEN-1:0] out_data;
  logic fwd_busy, fwd_wen;
  logic [RD_W-1:0] fwd_rd;
  logic [XLEN-1:0] fwd_data;

  lsu_mem_ctrl #(.XLEN(XLEN), .AW(AW), .RD_W(RD_W), .DEV_TOP(4'hA)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .in_wen(in_wen), .in_res(in_res),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_dev(ar_dev),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_err(r_err),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_dev(aw_dev),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
    .b_valid(b_valid), .b_ready(b_ready), .b_err(b_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_wen(out_wen),
    .out_data(out_data), .out_err(out_err),
    .fwd_busy(fwd_busy), .fwd_wen(fwd_wen), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] res;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] rdata;
    logic        rerr;
    logic        berr;
    logic [63:0] e_data;
    logic        e_err;
    logic        e_wen;
    logic [7:0]  e_strb;
    logic [63:0] e_wd;
    int          e_lat;
    logic        e_bus;
    logic        chk_data;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_op = 0; in_size = 0; in_unsigned = 0; in_addr = 0;
    in_wdata = 0; in_rd = 0; in_wen = 0; in_res = 0;
    ar_ready = 0; r_valid = 0; r_data = 0; r_err = 0;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_err = 0; out_ready = 0;
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] res,
                              input logic [4:0] rd, input logic wen, input logic [63:0] rdata,
                              input logic rerr, input logic berr, input logic [63:0] e_data,
                              input logic e_err, input logic e_wen, input logic [7:0] e_strb,
                              input logic [63:0] e_wd, input int e_lat, input logic e_bus,
                              input logic chk_data);
    vec_t v;
    v.op = op; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.res = res;
    v.rd = rd; v.wen = wen; v.rdata = rdata; v.rerr = rerr; v.berr = berr;
    v.e_data = e_data; v.e_err = e_err; v.e_wen = e_wen; v.e_strb = e_strb; v.e_wd = e_wd;
    v.e_lat = e_lat; v.e_bus = e_bus; v.chk_data = chk_data;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int i);
    int lat;
    logic saw_bus;
    logic [7:0] got_strb;
    logic [63:0] got_wd, mask;
    ar_ready = 1; aw_ready = 1; w_ready = 1; r_valid = 1; b_valid = 1;
    r_data = v.rdata; r_err = v.rerr; b_err = v.berr; out_ready = 0;
    in_valid = 1; in_op = v.op; in_size = v.size; in_unsigned = v.uns; in_addr = v.addr;
    in_wdata = v.wdata; in_res = v.res; in_rd = v.rd; in_wen = v.wen;
    tick();
    in_valid = 0; in_op = 0;
    #1;
    lat = 0; saw_bus = 0; got_strb = 0; got_wd = 0;
    for (int n = 0; n < 20; n++) begin
      if (ar_valid || aw_valid) saw_bus = 1;
      if (w_valid) begin got_strb = w_strb; got_wd = w_data; end
      if (out_valid) break;
      lat++;
      tick();
      #1;
    end
    chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'd1);
    chk($sformatf("v%0d latency", i), 64'(lat), 64'(v.e_lat));
    chk($sformatf("v%0d out_err", i), 64'(out_err), 64'(v.e_err));
    chk($sformatf("v%0d out_wen", i), 64'(out_wen), 64'(v.e_wen));
    chk($sformatf("v%0d out_rd", i), 64'(out_rd), 64'(v.rd));
    chk($sformatf("v%0d fwd_wen", i), 64'(fwd_wen), 64'(v.e_wen));
    chk($sformatf("v%0d bus_used", i), 64'(saw_bus), 64'(v.e_bus));
    if (v.chk_data) begin
      chk($sformatf("v%0d out_data", i), out_data, v.e_data);
      chk($sformatf("v%0d fwd_data", i), fwd_data, v.e_data);
    end
    if (v.e_bus && v.op == 2'd2) begin
      mask = '0;
      for (int b = 0; b < 8; b++) if (v.e_strb[b]) mask[8*b +: 8] = 8'hFF;
      chk($sformatf("v%0d w_strb", i), 64'(got_strb), 64'(v.e_strb));
      chk($sformatf("v%0d w_data", i), got_wd & mask, v.e_wd);
    end
    out_ready = 1;
    tick();
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx, nret;
    logic ok, ok_ready, ok_order;

    //       op  sz uns addr          wdata                   res                     rd wen rdata                   rerr berr e_data                  err wen strb   e_wd                    lat bus chk
    vt[0]  = mk(1, 0, 0, 32'h8000_0007, 64'h0,                64'h0,                  3, 1, 64'h8011_2233_4455_6677, 0, 0, 64'hFFFF_FFFF_FFFF_FF80, 0, 1, 8'h00, 64'h0,                  2, 1, 1);
    vt[1]  = mk(1, 0, 1, 32'h8000_0007, 64'h0,                64'h0,                  4, 1, 64'h8011_2233_4455_6677, 0, 0, 64'h0000_0000_0000_0080, 0, 1, 8'h00, 64'h0,                  2, 1, 1);
    vt[2]  = mk(1, 1, 0, 32'h8000_0002, 64'h0,                64'h0,                  5, 1, 64'h1111_2222_F00D_4444, 0, 0, 64'hFFFF_FFFF_FFFF_F00D, 0, 1, 8'h00, 64'h0,                  2, 1, 1);
    vt[3]  = mk(1, 1, 0, 32'h8000_0006, 64'h0,                64'h0,                  6, 1, 64'h7ABC_0000_0000_0000, 0, 0, 64'h0000_0000_0000_7ABC, 0, 1, 8'h00, 64'h0,                  2, 1, 1);
    vt[4]  = mk(1, 2, 0, 32'h8000_0004, 64'h0,                64'h0,                  8, 1, 64'h8765_4321_0000_0000, 0, 0, 64'hFFFF_FFFF_8765_4321, 0, 1, 8'h00, 64'h0,                  2, 1, 1);
    vt[5]  = mk(1, 2, 1, 32'h8000_0004, 64'h0,                64'h0,                  9, 1, 64'h8765_4321_0000_0000, 0, 0, 64'h0000_0000_8765_4321, 0, 1, 8'h00, 64'h0,                  2, 1, 1);
    vt[6]  = mk(1, 3, 0, 32'h8000_0008, 64'h0,                64'h0,                 10, 1, 64'h0123_4567_89AB_CDEF, 0, 0, 64'h0123_4567_89AB_CDEF, 0, 1, 8'h00, 64'h0,                  2, 1, 1);
    vt[7]  = mk(2, 0, 0, 32'h8000_0003, 64'hFFFF_FFFF_FFFF_FFAB, 64'h0,              11, 1, 64'h0,                  0, 0, 64'h0,                  0, 0, 8'h08, 64'h0000_0000_AB00_0000, 2, 1, 0);
    vt[8]  = mk(2, 2, 0, 32'h8000_0004, 64'h0000_0000_DEAD_BEEF, 64'h0,              12, 1, 64'h0,                  0, 0, 64'h0,                  0, 0, 8'hF0, 64'hDEAD_BEEF_0000_0000, 2, 1, 0);
    vt[9]  = mk(2, 3, 0, 32'h8000_0010, 64'h1122_3344_5566_7788, 64'h0,              13, 1, 64'h0,                  0, 0, 64'h0,                  0, 0, 8'hFF, 64'h1122_3344_5566_7788, 2, 1, 0);
    vt[10] = mk(0, 0, 0, 32'h0,         64'h0,                64'h5555_AAAA_0000_1234, 7, 1, 64'h0,                  0, 0, 64'h5555_AAAA_0000_1234, 0, 1, 8'h00, 64'h0,                  0, 0, 1);
    vt[11] = mk(1, 2, 0, 32'h8000_0002, 64'h0,                64'h0,                 14, 1, 64'h0,                  0, 0, 64'h0,                  1, 0, 8'h00, 64'h0,                  0, 0, 0);
    vt[12] = mk(1, 3, 0, 32'h8000_0018, 64'h0,                64'h0,                 15, 1, 64'hFFFF_0000_FFFF_0000, 1, 0, 64'h0,                  1, 0, 8'h00, 64'h0,                  2, 1, 0);
    vt[13] = mk(2, 3, 0, 32'h8000_0020, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0,              16, 1, 64'h0,                  0, 1, 64'h0,                  1, 0, 8'hFF, 64'hAAAA_BBBB_CCCC_DDDD, 2, 1, 0);
    vt[14] = mk(2, 1, 0, 32'h8000_0001, 64'h0000_0000_0000_BEEF, 64'h0,              17, 1, 64'h0,                  0, 0, 64'h0,                  1, 0, 8'h00, 64'h0,                  0, 0, 0);

    idle_inputs();
    rst = 1;
    tick();
    tick();
    #1;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset bus valids", 64'({ar_valid, aw_valid, w_valid, r_ready, b_ready}), 64'd0);
    chk("reset out_err", 64'(out_err), 64'd0);
    chk("reset out_data", out_data, 64'd0);
    chk("reset fwd", 64'({fwd_busy, fwd_wen}), 64'd0);
    rst = 0;
    tick();

    for (int i = 0; i < 15; i++) run_vec(vt[i], i);

    // sh with aw_ready two cycles after w_ready, b_valid late
    in_valid = 1; in_op = 2; in_size = 1; in_addr = 32'h8000_0006; in_wdata = 64'h1234;
    in_rd = 2; in_wen = 1; w_ready = 1; aw_ready = 0;
    tick();
    in_valid = 0; in_op = 0;
    #1;
    chk("sh w_strb", 64'(w_strb), 64'hC0);
    chk("sh w_data lane", 64'(w_data[63:48]), 64'h1234);
    chk("sh both valid", 64'({aw_valid, w_valid}), 64'h3);
    tick();
    w_ready = 0;
    #1;
    chk("sh after w hs", 64'({aw_valid, w_valid}), 64'h2);
    tick();
    #1;
    chk("sh aw held", 64'({aw_valid, out_valid}), 64'h2);
    aw_ready = 1;
    tick();
    aw_ready = 0;
    #1;
    chk("sh wresp", 64'({aw_valid, w_valid, b_ready, out_valid}), 64'h2);
    tick();
    #1;
    chk("sh wait b", 64'(out_valid), 64'd0);
    b_valid = 1;
    tick();
    b_valid = 0;
    #1;
    chk("sh hold", 64'({out_valid, out_wen, out_err}), 64'h4);
    out_ready = 1;
    tick();
    idle_inputs();

    // device-space load with r_valid delayed 5 cycles
    in_valid = 1; in_op = 1; in_size = 3; in_addr = 32'hA000_0048; in_rd = 9; in_wen = 1;
    tick();
    in_valid = 0; in_op = 0;
    #1;
    chk("dev ar_valid", 64'(ar_valid), 64'd1);
    chk("dev ar_addr", 64'(ar_addr), 64'hA000_0048);
    chk("dev ar_dev", 64'(ar_dev), 64'd1);
    ok = fwd_busy && !in_ready;
    ar_ready = 1;
    tick();
    ar_ready = 0;
    for (int n = 0; n < 5; n++) begin
      #1;
      if (!(fwd_busy && !in_ready && !out_valid && r_ready && !ar_valid)) ok = 0;
      tick();
    end
    #1;
    chk("dev busy window", 64'(ok), 64'd1);
    r_valid = 1; r_data = 64'hCAFE_F00D_1234_5678;
    tick();
    r_valid = 0;
    #1;
    chk("dev hold", 64'({out_valid, in_ready, fwd_busy, fwd_wen}), 64'h9);
    chk("dev data", fwd_data, 64'hCAFE_F00D_1234_5678);
    chk("dev fwd_rd", 64'(fwd_rd), 64'd9);
    out_ready = 1;
    tick();
    idle_inputs();

    // op=0 stream with out_ready toggling
    idx = 0; nret = 0; ok_ready = 1; ok_order = 1;
    for (int c = 0; c < 40; c++) begin
      in_valid = (idx < 4); in_op = 0; in_res = 64'h100 + 64'(idx); in_rd = 5'(idx); in_wen = 1;
      out_ready = (c % 2 == 0);
      #1;
      if (out_valid && (in_ready !== out_ready)) ok_ready = 0;
      if (out_valid && out_ready) begin
        if (out_data !== 64'h100 + 64'(nret)) ok_order = 0;
        nret++;
      end
      if (in_valid && in_ready) idx++;
      if (nret == 4) break;
      tick();
    end
    tick();
    idle_inputs();
    #1;
    chk("stream retired", 64'(nret), 64'd4);
    chk("stream accepted", 64'(idx), 64'd4);
    chk("stream in_ready track", 64'(ok_ready), 64'd1);
    chk("stream order", 64'(ok_order), 64'd1);
    chk("stream no extra", 64'(out_valid), 64'd0);
    tick();

    // reset during WRESP
    in_valid = 1; in_op = 2; in_size = 3; in_addr = 32'h8000_0020; in_wdata = 64'h77;
    aw_ready = 1; w_ready = 1;
    tick();
    in_valid = 0; in_op = 0;
    tick();
    #1;
    chk("rst pre wresp", 64'(b_ready), 64'd1);
    rst = 1; aw_ready = 0; w_ready = 0;
    tick();
    rst = 0;
    #1;
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst valids", 64'({ar_valid, aw_valid, w_valid, r_ready, b_ready, out_valid}), 64'd0);
    chk("rst out_err", 64'(out_err), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
